// File: rtl/conv_encoder.sv
// conv_encoder
//   Rate-1/2, constraint-length-3 convolutional encoder (transmit side of the
//   Viterbi link). Encodes FRAME_LEN info bits per frame into 2-bit symbols,
//   then appends two zero tail bits so the trellis returns to state 0.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      1-cycle pulse, starts a frame (only honoured in IDLE)
//   in_valid   in_bit is valid
//   in_bit     info bit
//   in_ready   bit is accepted this cycle (combinational)
//   out_valid  out_sym holds a symbol
//   out_sym    {G0 parity, G1 parity}
//   out_ready  downstream consumes out_sym this cycle
//   busy       frame in progress (state != IDLE)
//   frame_done 1-cycle pulse after the last tail symbol is consumed
module conv_encoder #(
    parameter int         FRAME_LEN = 16,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_sym,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

    // One extra bit so the counter can reach FRAME_LEN without wrapping.
    localparam int            CW       = $clog2(FRAME_LEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          tcnt;
    logic [1:0]    sr;          // sr[1] = previous bit, sr[0] = bit before that
    logic          slot_free;
    logic          load;
    logic          load_bit;
    logic          clr_frame;
    logic          done_nxt;
    logic [2:0]    win;
    logic [1:0]    sym_nxt;

    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != IDLE);

    // Window is {current, previous, previous-1}; parity over generator taps.
    assign win     = {load_bit, sr};
    assign sym_nxt = {^(win & G0), ^(win & G1)};

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        load_bit  = 1'b0;
        clr_frame = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_frame = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    load     = 1'b1;
                    load_bit = in_bit;
                    if (cnt == CNT_LAST) state_nxt = TAIL;
                end
            end
            TAIL: begin
                // Tail bits are zeros (load_bit default) to flush the trellis.
                if (slot_free) begin
                    load = 1'b1;
                    if (tcnt) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Last tail symbol sits in the output slot; wait for it to go.
                if (out_valid && out_ready) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr   <= 2'b00;
            cnt  <= '0;
            tcnt <= 1'b0;
        end else if (clr_frame) begin
            sr   <= 2'b00;
            cnt  <= '0;
            tcnt <= 1'b0;
        end else if (load) begin
            sr <= {load_bit, sr[1]};
            if (state == DATA) begin
                cnt  <= cnt + CW'(1);
                tcnt <= 1'b0;
            end else begin
                tcnt <= ~tcnt;
            end
        end
    end

    // Single-entry output slot; holds out_sym while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_sym   <= 2'b00;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sym   <= sym_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: FRAME_LEN=4 instance for the directed/random frames
// and a FRAME_LEN=16 instance for the all-zero frame. Expected symbols are
// queued as stimulus is issued; monitors pop and compare on each handshake.
module tb_conv_encoder;

    logic       clk = 1'b0;
    logic       reset;

    logic       start, in_valid, in_bit, out_ready;
    logic       in_ready, out_valid, busy, frame_done;
    logic [1:0] out_sym;

    logic       start_b, in_valid_b, in_bit_b, out_ready_b;
    logic       in_ready_b, out_valid_b, busy_b, frame_done_b;
    logic [1:0] out_sym_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_cons = 0;
    int last_cons_cyc = -10;
    int fd_cnt = 0;
    int b_cons = 0, b_acc = 0, b_fd = 0;
    bit rnd_rdy = 1'b0;

    logic [1:0] exp_q[$];
    logic       bit_q[$];
    logic [1:0] exp_b[$];
    logic [1:0] rx_s = 2'b00;

    logic [1:0] T1_SYM [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic       T1_BIT [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    conv_encoder #(.FRAME_LEN(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_bit(in_bit), .in_ready(in_ready), .out_valid(out_valid),
        .out_sym(out_sym), .out_ready(out_ready), .busy(busy),
        .frame_done(frame_done)
    );

    conv_encoder #(.FRAME_LEN(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid_b),
        .in_bit(in_bit_b), .in_ready(in_ready_b), .out_valid(out_valid_b),
        .out_sym(out_sym_b), .out_ready(out_ready_b), .busy(busy_b),
        .frame_done(frame_done_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // 7,5 reference: s[1] = previous bit, s[0] = the one before.
    function automatic logic [1:0] enc75(input logic b, input logic [1:0] s);
        return {b ^ s[1] ^ s[0], b ^ s[0]};
    endfunction

    task automatic push_t1();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(T1_SYM[i]);
            bit_q.push_back(T1_BIT[i]);
        end
    endtask

    // Monitor A: scoreboard plus a simple inverse decoder (loopback).
    initial begin : mon_a
        logic [1:0] e;
        logic       db, eb;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("sym_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sym", int'(out_sym), int'(e));
                end
                db   = out_sym[0] ^ rx_s[0];
                rx_s = {db, rx_s[1]};
                if (bit_q.size() != 0) begin
                    eb = bit_q.pop_front();
                    chk("loopback_bit", int'(db), int'(eb));
                end
                n_cons++;
                last_cons_cyc = cyc;
            end
            if (frame_done) fd_cnt++;
        end
    end

    initial begin : mon_b
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (reset && out_valid_b && out_ready_b) begin
                if (exp_b.size() == 0) chk("b_sym_unexpected", 1, 0);
                else begin
                    e = exp_b.pop_front();
                    chk("b_sym", int'(out_sym_b), int'(e));
                end
                b_cons++;
            end
            if (reset && in_valid_b && in_ready_b) b_acc++;
            if (frame_done_b) b_fd++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Start a frame and feed n bits; glitch pulses start in DATA and TAIL.
    task automatic drive(input logic [15:0] bits, input int n, input bit glitch);
        int k;
        bit acc;
        @(posedge clk); #1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_bit   = ~bits[0];          // offered while IDLE: must not be taken
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            if (glitch && i == 2) start = 1'b1;
            k   = 0;
            acc = 1'b0;
            while (!acc && k < 100) begin
                @(negedge clk);
                acc = in_ready;
                k++;
            end
            chk("bit_accepted", int'(acc), 1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (glitch) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic stall();
        int base = n_cons;
        int k = 0;
        while (n_cons < base + 1 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_hold_sym", int'(out_sym), 2);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic wait_done();
        int k = 0;
        bit seen = 1'b0;
        while (!seen && k < 300) begin
            @(negedge clk);
            seen = frame_done;
            k++;
        end
        chk("frame_done_seen", int'(seen), 1);
        if (seen) begin
            chk("frame_done_lag", cyc - last_cons_cyc, 1);
            chk("exp_drained", exp_q.size(), 0);
            @(negedge clk);
            chk("frame_done_pulse", int'(frame_done), 0);
            chk("busy_after_frame", int'(busy), 0);
        end
    endtask

    initial begin : main
        int k;
        bit seen;
        logic [15:0] rb;
        logic [1:0]  msr;
        logic        mb;

        reset = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        start_b = 1'b0; in_valid_b = 1'b0; in_bit_b = 1'b0; out_ready_b = 1'b1;

        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sym", int'(out_sym), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        #19 reset = 1'b1;

        // All-zero frame, FRAME_LEN=16: 18 symbols of 00.
        for (int i = 0; i < 18; i++) exp_b.push_back(2'b00);
        @(posedge clk); #1;
        start_b = 1'b1; in_valid_b = 1'b1; in_bit_b = 1'b0;
        @(posedge clk); #1;
        start_b = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            seen = frame_done_b;
            k++;
        end
        chk("b_frame_done", int'(seen), 1);
        in_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("b_sym_count", b_cons, 18);
        chk("b_accept_count", b_acc, 16);
        chk("b_frame_done_count", b_fd, 1);
        chk("b_exp_drained", exp_b.size(), 0);
        chk("b_busy_after", int'(busy_b), 0);

        // Directed frame 1,0,1,1 at full throughput.
        push_t1();
        drive(16'b1101, 4, 1'b0);
        wait_done();

        // Same frame with a 3-cycle downstream stall on the second symbol.
        push_t1();
        fork
            drive(16'b1101, 4, 1'b0);
            stall();
        join
        wait_done();

        // Stray start pulses during DATA and TAIL.
        push_t1();
        drive(16'b1101, 4, 1'b1);
        wait_done();

        // Reset while the second symbol is held, then a clean frame.
        exp_q.push_back(2'b11);
        bit_q.push_back(1'b1);
        drive(16'b01, 2, 1'b0);
        chk("pre_rst_valid", int'(out_valid), 1);
        chk("pre_rst_sym", int'(out_sym), 2);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk("first_sym_out", exp_q.size(), 0);
        #1 reset = 1'b1;
        exp_q.delete();
        bit_q.delete();
        rx_s = 2'b00;
        push_t1();
        drive(16'b1101, 4, 1'b0);
        wait_done();

        // Back-to-back random frames with random backpressure.
        rnd_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            rb  = 16'($urandom);
            msr = 2'b00;
            for (int i = 0; i < 6; i++) begin
                mb = (i < 4) ? rb[i] : 1'b0;
                exp_q.push_back(enc75(mb, msr));
                bit_q.push_back(mb);
                msr = {mb, msr[1]};
            end
            drive(rb, 4, 1'b0);
            wait_done();
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("frame_done_total", fd_cnt, 7);
        chk("final_exp_empty", exp_q.size(), 0);
        chk("final_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
